// File: rtl/key_delay_pkg.sv
// key_delay_pkg: shared types and helpers for the front-panel key conditioner.
//   kd_state_t   - per-channel FSM state encoding
//   cnt_width()  - counter width able to hold the longer of the two windows
package key_delay_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    LOCKOUT      = 2'd1,
    WAIT_RELEASE = 2'd2,
    REPEAT       = 2'd3
  } kd_state_t;

  function automatic int cnt_width(input int delay_cycles, input int repeat_cycles);
    int longest;
    longest = (delay_cycles > repeat_cycles) ? delay_cycles : repeat_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/key_delay_channel.sv
// key_delay_channel: one key channel - 2-flop synchroniser, window counter, FSM.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   keyhit      raw key level, asynchronous to clk
//   repeat_en   0 = one-shot, 1 = auto-repeat (sampled only at window ends)
//   press_pulse registered one-cycle pulse per accepted press or repeat
//   busy        registered, 1 while in LOCKOUT or REPEAT
//
// state        | meaning
// IDLE         | waiting for a synchronised press
// LOCKOUT      | post-press window, key changes ignored until it expires
// WAIT_RELEASE | one-shot hold, waiting for key release
// REPEAT       | key held in auto-repeat mode, pulse every repeat period
module key_delay_channel
  import key_delay_pkg::*;
#(
  parameter int DELAY_CYCLES  = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic keyhit,
  input  logic repeat_en,
  output logic press_pulse,
  output logic busy
);

  localparam int CW = cnt_width(DELAY_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  logic          key_meta;
  logic          ksync;
  logic [CW-1:0] cnt;
  kd_state_t     state;

  // busy is set/cleared on the same edge as the state change so that it is
  // high exactly while the FSM sits in LOCKOUT or REPEAT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_meta    <= 1'b0;
      ksync       <= 1'b0;
      cnt         <= '0;
      state       <= IDLE;
      press_pulse <= 1'b0;
      busy        <= 1'b0;
    end else begin
      key_meta    <= keyhit;
      ksync       <= key_meta;
      press_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ksync) begin
            press_pulse <= 1'b1;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= LOCKOUT;
          end
        end
        LOCKOUT: begin
          if (cnt == DELAY_LAST) begin
            cnt <= '0;
            if (!ksync) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (repeat_en) begin
              state <= REPEAT;
            end else begin
              busy  <= 1'b0;
              state <= WAIT_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (!ksync) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        REPEAT: begin
          if (cnt == REPEAT_LAST) begin
            cnt <= '0;
            if (!ksync) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (repeat_en) begin
              press_pulse <= 1'b1;
            end else begin
              busy  <= 1'b0;
              state <= WAIT_RELEASE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_delay_multi.sv
// key_delay_multi: N_KEYS independent key conditioners plus a shared busy flag.
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   keyhit      raw key levels, active-high, asynchronous
//   repeat_en   per-channel mode, 0 = one-shot, 1 = auto-repeat
//   press_pulse one-cycle pulse per accepted press or repeat
//   busy        per-channel lockout/repeat window flag
//   any_busy    OR of busy (combinational)
module key_delay_multi
  import key_delay_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int DELAY_CYCLES  = 50000000,
  parameter int REPEAT_CYCLES = 12500000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] keyhit,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] busy,
  output logic              any_busy
);

  if (N_KEYS < 1) begin : g_bad_n_keys
    $error("key_delay_multi: N_KEYS must be >= 1");
  end
  if (DELAY_CYCLES < 1) begin : g_bad_delay
    $error("key_delay_multi: DELAY_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("key_delay_multi: REPEAT_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
    key_delay_channel #(
      .DELAY_CYCLES (DELAY_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset_n    (reset_n),
      .keyhit     (keyhit[i]),
      .repeat_en  (repeat_en[i]),
      .press_pulse(press_pulse[i]),
      .busy       (busy[i])
    );
  end

  assign any_busy = |busy;

endmodule

// File: doc/key_delay_multi.md
Name: key_delay_multi

Overview:
Multi-channel keypress conditioner for the front-panel keys. It is the parametrised successor of the single-key lockout delay. Each channel synchronises an asynchronous key input and emits a one-cycle accepted-press pulse. It then holds a lockout window and either waits for release (one-shot mode) or issues periodic repeat pulses while the key stays held (auto-repeat mode). It sits between the raw key pins and the wire-cutter control FSM.

Parameters:
N_KEYS, 4, number of independent key channels (>=1)
DELAY_CYCLES, 50000000, lockout length after an accepted press, in clk cycles (>=1)
REPEAT_CYCLES, 12500000, auto-repeat period after the lockout, in clk cycles (>=1)

Ports:
clk  input  1  system clock, single clock domain
reset_n  input  1  asynchronous active-low reset
keyhit  input  N_KEYS  raw key levels, active-high, asynchronous to clk
repeat_en  input  N_KEYS  per-channel mode: 0 = one-shot, 1 = auto-repeat
press_pulse  output  N_KEYS  one-cycle pulse per accepted press or repeat
busy  output  N_KEYS  1 while the channel is in a lockout or repeat window
any_busy  output  1  OR-reduction of busy

Behaviour:
- Reset (async, reset_n=0):
  - All sync flops, counters and outputs go to 0.
  - Every channel FSM goes to IDLE.
  - Applies immediately, including mid-lockout or mid-repeat; no pending pulse survives.
- Synchroniser: 2-flop per channel; ksync is stage 2. The FSM acts only on ksync.
- Latency: keyhit rising, first sampled at edge k, gives press_pulse=1 in the cycle after edge k+2.
- Counter: per channel, width $clog2(max(DELAY_CYCLES,REPEAT_CYCLES)+1). Never wraps; it is reloaded to 0 on every state entry.
- FSM per channel, states IDLE, LOCKOUT, WAIT_RELEASE, REPEAT:
  - IDLE: busy=0. If ksync=1, then press_pulse=1, cnt<=0, go to LOCKOUT.
  - LOCKOUT: busy=1, cnt increments. At cnt==DELAY_CYCLES-1:
    - ksync=0 -> IDLE.
    - ksync=1 and repeat_en=1 -> REPEAT with cnt<=0, no pulse.
    - ksync=1 and repeat_en=0 -> WAIT_RELEASE.
    - busy is therefore high for exactly DELAY_CYCLES cycles.
  - WAIT_RELEASE: busy=0, no pulses. ksync=0 -> IDLE. A new press requires release, then press again.
  - REPEAT: busy=1, cnt increments. At cnt==REPEAT_CYCLES-1:
    - ksync=1 -> press_pulse=1, cnt<=0, stay in REPEAT.
    - ksync=0 -> IDLE.
    - In REPEAT, repeat_en=0 forces WAIT_RELEASE (or IDLE if ksync=0) at the end of the period.
    - Steady held-key pulse spacing is REPEAT_CYCLES.
- Key release during LOCKOUT does not shorten the window; the channel still reaches IDLE only at lockout end. This preserves bounce immunity.
- Mode sampling: repeat_en is sampled only at window-end decisions; no glitch filtering is applied to it.
- Channel independence: channels share no state. Simultaneous presses on any subset give simultaneous pulses.
- Output registering: press_pulse and busy are registered outputs. any_busy is combinational OR of the busy registers.
- Key held through reset deassertion: treated as a fresh press; the pulse appears 3 edges after release of reset.
- Elaboration: assertion fails if N_KEYS<1, DELAY_CYCLES<1 or REPEAT_CYCLES<1.

Decomposition:
- Package key_delay_pkg holds:
  - typedef enum logic [1:0] kd_state_t {IDLE, LOCKOUT, WAIT_RELEASE, REPEAT};
  - a function computing the counter width from the two cycle parameters.
- Sub-module key_delay_channel, one per channel:
  - contains the synchroniser, counter and FSM;
  - has scalar keyhit/repeat_en/press_pulse/busy;
  - takes DELAY_CYCLES and REPEAT_CYCLES.
- Top level is a generate loop over N_KEYS plus the any_busy reduction.

Test Plan:
All scenarios use N_KEYS=4, DELAY_CYCLES=5, REPEAT_CYCLES=3.

1. One-shot press: key0 high 20 cycles, repeat_en=0 -> exactly one press_pulse[0], 3 edges after the rise. busy[0] is high for 5 cycles, then 0. No further pulses until release and re-press.
2. Bounce: key0 toggles every cycle for 4 cycles, then stays low -> one pulse, busy 5 cycles, FSM back to IDLE, no second pulse.
3. Auto-repeat: key1 held 30 cycles, repeat_en[1]=1 -> first pulse, then pulses every 3 cycles starting 5+3 cycles after the first. Release gives IDLE within 3 cycles and no extra pulse.
4. Simultaneous: keys 0-3 rise in the same cycle with mixed repeat_en=4'b1010 -> four pulses in the same cycle. Repeats appear only on channels 1 and 3. any_busy=1 while any channel is busy.
5. Reset mid-lockout: reset_n=0 during cycle 2 of LOCKOUT -> busy, press_pulse and any_busy are 0 immediately. Key still high after reset release gives a new pulse 3 edges later.
6. Mode change: repeat_en[2] goes 1->0 while in REPEAT with the key held -> no pulse at the next period end. Channel enters WAIT_RELEASE with busy=0.
